// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and per-channel mode helpers shared by the SPI bus master files
package spi_pkg;
    typedef enum logic [2:0] {IDLE, GRANT, SETUP, SHIFT, HOLD, GAP} state_t;
    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;
    function automatic logic [1:0] chan_mode(input logic [15:0] modes, input int ch);
        return 2'(modes >> (2 * ch));
    endfunction
endpackage

// File: rtl/spi_bus_master_if.sv
// spi_bus_master_if: client handshake and shared SPI pins of the bus master
interface spi_bus_master_if #(
    parameter int NCH = 2,
    parameter int WIDTH = 16
);
    logic [NCH-1:0] req;
    logic [NCH*WIDTH-1:0] tx_data;
    logic [NCH-1:0] ack;
    logic [WIDTH-1:0] rx_data;
    logic busy;
    logic sclk;
    logic mosi;
    logic miso;
    logic [NCH-1:0] cs_n;
    modport master (input req, tx_data, miso, output ack, rx_data, busy, sclk, mosi, cs_n);
    modport slave (output req, tx_data, miso, input ack, rx_data, busy, sclk, mosi, cs_n);
endinterface

// File: rtl/spi_shifter.sv
// spi_shifter: generates SCLK for one transfer, shifting MOSI out MSB first and MISO in LSB first
module spi_shifter #(
    parameter int WIDTH = 16,
    parameter int CLKDIV = 4,
    parameter logic RST_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             start,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [WIDTH-1:0] data,
    input  logic             miso,
    output logic             sclk,
    output logic             mosi,
    output logic             done,
    output logic [WIDTH-1:0] rx
);
    localparam int HW = $clog2(CLKDIV);
    localparam int EW = $clog2(2 * WIDTH);

    logic [HW-1:0] hcnt;
    logic [EW-1:0] ecnt;
    logic [WIDTH-1:0] sh;
    logic pha, run, tick, sample;

    assign tick = run && hcnt == HW'(CLKDIV - 1);
    assign done = tick && ecnt == EW'(2 * WIDTH - 1);
    // even edge numbers are leading edges; CPHA=0 samples there, CPHA=1 on trailing ones
    assign sample = pha ^ ~ecnt[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            ecnt <= '0;
            sh <= '0;
            rx <= '0;
            pha <= 1'b0;
            run <= 1'b0;
            sclk <= RST_POL;
            mosi <= 1'b0;
        end else if (load) begin
            sh <= cpha ? data : data << 1;
            pha <= cpha;
            sclk <= cpol;
            if (!cpha) mosi <= data[WIDTH-1];
        end else if (start) begin
            run <= 1'b1;
            hcnt <= '0;
            ecnt <= '0;
        end else if (run) begin
            hcnt <= tick ? '0 : hcnt + 1'b1;
            if (tick) begin
                sclk <= ~sclk;
                ecnt <= ecnt + 1'b1;
                run <= !done;
                if (sample) rx <= {rx[WIDTH-2:0], miso};
                else if (!done) begin
                    mosi <= sh[WIDTH-1];
                    sh <= sh << 1;
                end
            end
        end
    end
endmodule

// File: rtl/spi_bus_master.sv
// spi_bus_master: round-robin arbiter and framing FSM sharing one SPI bus among NCH clients
module spi_bus_master
    import spi_pkg::*;
#(
    parameter int NCH = 2,
    parameter int WIDTH = 16,
    parameter int CLKDIV = 4,
    parameter logic [2*NCH-1:0] MODE = '0
) (
    input logic clk,
    input logic rst_n,
    spi_bus_master_if.master bus
);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    localparam int DW = $clog2(CLKDIV);

    if (CLKDIV < 2) begin : g_bad_div
        $error("CLKDIV must be at least 2");
    end

    state_t state, state_nxt;
    logic [CW-1:0] g, rr, pick, idx;
    logic [DW-1:0] cnt;
    logic [1:0] gmode;
    logic [WIDTH-1:0] rx;
    logic found, last, load, start, done;

    assign last = cnt == DW'(CLKDIV - 1);
    assign gmode = chan_mode(16'(MODE), int'(g));
    assign bus.busy = state != IDLE;

    // scan from the farthest offset down so the nearest requester at or after rr wins
    always_comb begin
        pick = '0;
        idx = '0;
        found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = CW'((int'(rr) + i) % NCH);
            if (bus.req[idx]) begin
                pick = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load = 1'b0;
        start = 1'b0;
        case (state)
            IDLE:    state_nxt = found ? GRANT : IDLE;
            GRANT: begin
                state_nxt = SETUP;
                load = 1'b1;
            end
            SETUP: begin
                state_nxt = last ? SHIFT : SETUP;
                start = last;
            end
            SHIFT:   state_nxt = done ? HOLD : SHIFT;
            HOLD:    state_nxt = last ? GAP : HOLD;
            GAP:     state_nxt = last ? IDLE : GAP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            g <= '0;
            rr <= '0;
            bus.cs_n <= '1;
            bus.ack <= '0;
            bus.rx_data <= '0;
        end else begin
            cnt <= state_nxt != state ? '0 : cnt + 1'b1;
            bus.ack <= '0;
            if (state == IDLE) g <= pick;
            if (load) bus.cs_n <= ~(NCH'(1) << g);
            if (state == HOLD && last) begin
                bus.cs_n <= '1;
                bus.ack <= NCH'(1) << g;
                bus.rx_data <= rx;
                rr <= g == CW'(NCH - 1) ? '0 : g + 1'b1;
            end
        end
    end

    spi_shifter #(.WIDTH(WIDTH), .CLKDIV(CLKDIV), .RST_POL(MODE[CPOL_BIT])) u_shifter (
        .clk,
        .rst_n,
        .load,
        .start,
        .cpol(gmode[CPOL_BIT]),
        .cpha(gmode[CPHA_BIT]),
        .data(bus.tx_data[int'(g)*WIDTH +: WIDTH]),
        .miso(bus.miso),
        .sclk(bus.sclk),
        .mosi(bus.mosi),
        .done,
        .rx
    );
endmodule

// File: tb/tb_spi_bus_master.sv
// tb_spi_bus_master: directed scenarios for the shared-bus SPI master (2-channel and 4-channel builds)
module tb_spi_bus_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic loop_a = 1'b1;
    logic s_miso = 1'b0, s_prev = 1'b0;
    logic [15:0] s_word = '0, s_sh = '0, s_in = '0;

    always #5 clk = ~clk;

    spi_bus_master_if #(.NCH(2), .WIDTH(16)) ifa ();
    spi_bus_master_if #(.NCH(4), .WIDTH(8)) ifb ();

    spi_bus_master #(.MODE(4'b1100)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
    spi_bus_master #(.NCH(4), .WIDTH(8), .CLKDIV(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

    assign ifa.miso = loop_a ? ifa.mosi : s_miso;
    assign ifb.miso = ifb.mosi;

    // mode-3 slave on channel 1: drive on falling (leading) edges, capture on rising (trailing) edges
    always @(negedge clk) begin
        if (ifa.cs_n[1]) s_sh <= s_word;
        else if (ifa.sclk != s_prev) begin
            if (!ifa.sclk) begin
                s_miso <= s_sh[15];
                s_sh <= s_sh << 1;
            end else s_in <= {s_in[14:0], ifa.mosi};
        end
        s_prev <= ifa.sclk;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ifa.cs_n !== 2'b11) begin errors++; $display("FAIL reset_cs_n got=%b exp=11", ifa.cs_n); end
        checks++; if (ifa.ack !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", ifa.ack); end
        checks++; if (ifa.rx_data !== 16'h0) begin errors++; $display("FAIL reset_rx got=%h exp=0000", ifa.rx_data); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", ifa.busy); end
        checks++; if (ifa.sclk !== 1'b0 || ifa.mosi !== 1'b0) begin errors++; $display("FAIL reset_pins got=%b%b exp=00", ifa.sclk, ifa.mosi); end
        checks++; if (ifb.cs_n !== 4'hF) begin errors++; $display("FAIL reset_cs_n_b got=%b exp=1111", ifb.cs_n); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        int cs_len = 0, lead = 0, acks = 0, first = 0;
        logic prev, bad = 1'b0;
        logic [15:0] rx = '0;
        loop_a = 1'b1;
        ifa.tx_data[15:0] = 16'hA5C3;
        ifa.req = 2'b01;
        prev = ifa.sclk;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (ifa.cs_n == 2'b10) begin
                cs_len++;
                if (first == 0) first = i;
                if (ifa.sclk && !prev) lead++;
            end
            if (ifa.cs_n == 2'b00 || ifa.cs_n == 2'b01) bad = 1'b1;
            prev = ifa.sclk;
            if (ifa.ack != 2'b00) begin
                acks++;
                rx = ifa.rx_data;
                if (ifa.ack != 2'b01) bad = 1'b1;
                ifa.req = 2'b00;
            end
        end
        checks++; if (first != 2) begin errors++; $display("FAIL lb_latency got=%0d exp=2", first); end
        checks++; if (cs_len != 136) begin errors++; $display("FAIL lb_cs_len got=%0d exp=136", cs_len); end
        checks++; if (lead != 16) begin errors++; $display("FAIL lb_lead_edges got=%0d exp=16", lead); end
        checks++; if (acks != 1) begin errors++; $display("FAIL lb_acks got=%0d exp=1", acks); end
        checks++; if (rx !== 16'hA5C3) begin errors++; $display("FAIL lb_rx got=%h exp=a5c3", rx); end
        checks++; if (bad) begin errors++; $display("FAIL lb_wrong_select got=1 exp=0"); end
        checks++; if (ifa.sclk !== 1'b0 || ifa.busy !== 1'b0) begin errors++; $display("FAIL lb_idle got=%b%b exp=00", ifa.sclk, ifa.busy); end
    endtask

    task automatic test_mode3();
        int viol = 0, acks = 0;
        logic bp = 1'b0;
        logic [1:0] ak = '0;
        logic [15:0] rx = '0;
        s_word = 16'h1234;
        loop_a = 1'b0;
        ifa.tx_data[31:16] = 16'h8001;
        ifa.req = 2'b10;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifa.busy && bp && ifa.cs_n[1] && !ifa.sclk) viol++;
            bp = ifa.busy;
            if (ifa.ack != 2'b00) begin
                acks++;
                ak = ifa.ack;
                rx = ifa.rx_data;
                ifa.req = 2'b00;
            end
        end
        loop_a = 1'b1;
        checks++; if (viol != 0) begin errors++; $display("FAIL m3_sclk_idle got=%0d exp=0", viol); end
        checks++; if (acks != 1 || ak !== 2'b10) begin errors++; $display("FAIL m3_ack got=%0d/%b exp=1/10", acks, ak); end
        checks++; if (rx !== 16'h1234) begin errors++; $display("FAIL m3_rx got=%h exp=1234", rx); end
        checks++; if (s_in !== 16'h8001) begin errors++; $display("FAIL m3_slave_rx got=%h exp=8001", s_in); end
        checks++; if (ifa.sclk !== 1'b1) begin errors++; $display("FAIL m3_sclk_end got=%b exp=1", ifa.sclk); end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [4];
        logic [15:0] rx = '0;
        int n = 0, gap = 0, gmin = 1000, gmax = 0;
        logic started = 1'b0, bad = 1'b0;
        ifa.tx_data = {16'h0F0F, 16'hF00F};
        ifa.req = 2'b11;
        for (int i = 0; i < 1000 && n < 4; i++) begin
            @(negedge clk);
            if (ifa.cs_n == 2'b00) bad = 1'b1;
            if (ifa.cs_n == 2'b11) begin
                if (started) gap++;
            end else begin
                if (gap > 0) begin
                    gmin = gap < gmin ? gap : gmin;
                    gmax = gap > gmax ? gap : gmax;
                end
                gap = 0;
                started = 1'b1;
            end
            if (ifa.ack != 2'b00) begin
                order[n] = ifa.ack;
                rx = ifa.rx_data;
                n++;
            end
        end
        ifa.req = 2'b00;
        for (int i = 0; i < 50 && ifa.busy; i++) @(negedge clk);
        checks++; if (n != 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", n); end
        else begin
            checks++; if (order[0] !== 2'b01 || order[1] !== 2'b10 || order[2] !== 2'b01 || order[3] !== 2'b10) begin
                errors++; $display("FAIL rr_order got=%b,%b,%b,%b exp=01,10,01,10", order[0], order[1], order[2], order[3]);
            end
        end
        checks++; if (bad) begin errors++; $display("FAIL rr_two_selects got=1 exp=0"); end
        checks++; if (gmin != 6 || gmax != 6) begin errors++; $display("FAIL rr_gap got=%0d..%0d exp=6..6", gmin, gmax); end
        checks++; if (rx !== 16'h0F0F) begin errors++; $display("FAIL rr_last_rx got=%h exp=0f0f", rx); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rr_settle got=%b exp=0", ifa.busy); end
    endtask

    task automatic test_drop();
        int acks = 0, falls = 0;
        logic prev = 1'b0;
        logic [15:0] rx = '0;
        ifa.tx_data[15:0] = 16'h5AA5;
        ifa.req = 2'b01;
        for (int i = 0; i < 20 && ifa.cs_n[0]; i++) @(negedge clk);
        checks++; if (ifa.cs_n[0] !== 1'b0) begin errors++; $display("FAIL drop_start got=%b exp=0", ifa.cs_n[0]); end
        repeat (14) @(negedge clk);
        ifa.req = 2'b00;
        checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL drop_busy got=%b exp=1", ifa.busy); end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (prev && !ifa.cs_n[0]) falls++;
            prev = ifa.cs_n[0];
            if (ifa.ack[0]) begin
                acks++;
                rx = ifa.rx_data;
            end
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL drop_acks got=%0d exp=1", acks); end
        checks++; if (falls != 0) begin errors++; $display("FAIL drop_extra got=%0d exp=0", falls); end
        checks++; if (rx !== 16'h5AA5) begin errors++; $display("FAIL drop_rx got=%h exp=5aa5", rx); end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        logic [1:0] ak = '0;
        logic [15:0] rx = '0;
        ifa.tx_data[31:16] = 16'h3C5A;
        ifa.req = 2'b10;
        for (int i = 0; i < 10 && !ifa.busy; i++) @(negedge clk);
        checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL rm_grant got=%b exp=1", ifa.busy); end
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (ifa.cs_n !== 2'b11) begin errors++; $display("FAIL rm_cs_n got=%b exp=11", ifa.cs_n); end
        checks++; if (ifa.ack !== 2'b00 || ifa.busy !== 1'b0) begin errors++; $display("FAIL rm_ack_busy got=%b/%b exp=00/0", ifa.ack, ifa.busy); end
        checks++; if (ifa.rx_data !== 16'h0) begin errors++; $display("FAIL rm_rx got=%h exp=0000", ifa.rx_data); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifa.ack != 2'b00) begin
                acks++;
                ak = ifa.ack;
                rx = ifa.rx_data;
                ifa.req = 2'b00;
            end
        end
        checks++; if (acks != 1 || ak !== 2'b10) begin errors++; $display("FAIL rm_after_ack got=%0d/%b exp=1/10", acks, ak); end
        checks++; if (rx !== 16'h3C5A) begin errors++; $display("FAIL rm_after_rx got=%h exp=3c5a", rx); end
    endtask

    task automatic test_nch4();
        logic [3:0] ord [3];
        logic [7:0] rxs [3];
        int len [3];
        int n = 0, run = 0;
        logic bad = 1'b0;
        ifb.tx_data = {8'h44, 8'h00, 8'h22, 8'h11};
        ifb.req = 4'b1011;
        for (int i = 0; i < 400 && n < 3; i++) begin
            @(negedge clk);
            if (ifb.cs_n != 4'hF) begin
                run++;
                if ($countones(~ifb.cs_n) != 1) bad = 1'b1;
            end
            if (ifb.ack != 4'h0) begin
                ord[n] = ifb.ack;
                len[n] = run;
                rxs[n] = ifb.rx_data;
                run = 0;
                ifb.req = ifb.req & ~ifb.ack;
                n++;
            end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL n4_count got=%0d exp=3", n); end
        else begin
            checks++; if (ord[0] !== 4'b0001 || ord[1] !== 4'b0010 || ord[2] !== 4'b1000) begin
                errors++; $display("FAIL n4_order got=%b,%b,%b exp=0001,0010,1000", ord[0], ord[1], ord[2]);
            end
            checks++; if (len[0] != 36 || len[1] != 36 || len[2] != 36) begin
                errors++; $display("FAIL n4_cs_len got=%0d,%0d,%0d exp=36,36,36", len[0], len[1], len[2]);
            end
            checks++; if (rxs[0] !== 8'h11 || rxs[1] !== 8'h22 || rxs[2] !== 8'h44) begin
                errors++; $display("FAIL n4_rx got=%h,%h,%h exp=11,22,44", rxs[0], rxs[1], rxs[2]);
            end
        end
        checks++; if (bad) begin errors++; $display("FAIL n4_select got=1 exp=0"); end
    endtask

    initial begin
        ifa.req = '0;
        ifa.tx_data = '0;
        ifb.req = '0;
        ifb.tx_data = '0;
        test_reset();
        test_loopback();
        test_mode3();
        test_round_robin();
        test_drop();
        test_reset_mid();
        test_nch4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_bus_master.md
Name: spi_bus_master

Overview:
Parametrised shared-bus SPI master serving NCH client channels over one SCLK/MOSI/MISO bus with a per-channel active-low chip select.
- Replaces ad-hoc SCLK muxing between peripheral drivers (light sensor, accelerometer) with round-robin arbitration.
- Per-channel SPI mode and a programmable SCLK divider.
- Sits between the sensor-driver FSMs and the Pmod pins at top level.

Parameters:
NCH, 2, number of client channels / chip selects (1..8)
WIDTH, 16, bits per transfer, MSB first (8..32)
CLKDIV, 4, Clock cycles per SCLK half-period (>=2; smaller is an elaboration error)
MODE, {NCH{2'b00}}, 2 bits per channel {CPOL,CPHA}; channel i uses MODE[2i+1:2i]

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous active-low reset
req  in  NCH  per-channel transfer request, level; hold until ack
tx_data  in  NCH*WIDTH  per-channel transmit word, slice i = [WIDTH*i +: WIDTH]; stable while req high
ack  out  NCH  one-cycle pulse on channel whose transfer completed
rx_data  out  WIDTH  received word; valid in ack cycle, held until next ack
busy  out  1  high from grant until return to IDLE
SCLK  out  1  shared serial clock
MOSI  out  1  shared serial data out
MISO  in  1  shared serial data in
CS_n  out  NCH  active-low chip selects, at most one low

Behaviour:
- Reset (async assert, sync release): state=IDLE, CS_n all 1, SCLK=CPOL of channel 0, MOSI=0, ack=0, rx_data=0, busy=0, rr pointer=0.
- States: IDLE -> GRANT -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: if any req, pick the first requesting channel at or after rr pointer (wrapping); go to GRANT next cycle. Without req, stay in IDLE.
- GRANT, 1 cycle:
  - Latch channel index g and tx_data[g].
  - Set SCLK=CPOL[g].
  - busy=1.
  - If CPHA[g]=0, drive MOSI with the MSB.
- SETUP, CLKDIV cycles: CS_n[g]=0, SCLK idle.
- SHIFT, 2*WIDTH half-periods of CLKDIV cycles each; SCLK toggles at each half-period boundary.
  - CPHA=0: sample MISO on leading edges, shift MOSI on trailing edges (the final trailing edge does not shift).
  - CPHA=1: shift MOSI on leading edges (first leading edge presents the MSB), sample MISO on trailing edges.
  - MISO is sampled into an LSB-in shift register.
  - After the last edge SCLK equals CPOL[g].
- HOLD, CLKDIV cycles: CS_n[g] stays low, SCLK idle.
- On HOLD exit:
  - CS_n[g]=1.
  - rx_data takes the shift register.
  - ack[g]=1 for exactly that cycle.
  - rr pointer = (g+1) mod NCH.
- GAP, CLKDIV cycles: all CS_n high (minimum deselect time), then IDLE with busy=0.
- Latency: req seen in IDLE -> CS_n low 2 cycles later. CS_n low time = (2*WIDTH+2)*CLKDIV cycles. Back-to-back throughput bounded by GAP + IDLE + GRANT.
- req deasserted mid-transfer: the transfer completes and ack still pulses. A req changing while not granted has no effect until the next IDLE.
- Requests arriving during a transfer wait; no preemption.
- Simultaneous requests: round-robin guarantees each requester is served within NCH transfers.
- A client re-asserting req in its ack cycle is eligible at the next IDLE, but only after the others per rr order.
- Reset mid-transfer: CS_n immediately all high, no ack, rx_data cleared.
- SCLK, MOSI, CS_n driven from flops (no glitches).
- Only the granted channel's MODE affects the bus.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, GRANT, SETUP, SHIFT, HOLD, GAP)
  - CPOL/CPHA bit-index constants
  - function extracting a channel's mode from MODE
- Sub-module spi_shifter:
  - half-period counter, edge counter, SCLK generation, MOSI shift/MISO sample for one transfer
  - start/done handshake
- spi_bus_master keeps arbitration, CS decode and the top FSM.

Test Plan:
- Defaults. Ch0 req with tx 16'hA5C3, MISO looped to MOSI:
  - CS_n=2'b10 for exactly 136 cycles.
  - 16 leading SCLK edges.
  - ack=2'b01 once, rx_data=16'hA5C3.
- MODE ch1=2'b11. Ch1 req with tx 16'h8001, MISO from a slave model returning 16'h1234:
  - SCLK high whenever CS_n[1] is high.
  - Slave receives 16'h8001, rx_data=16'h1234, ack=2'b10.
- Both req held high continuously: grants alternate ch0, ch1, ch0, ch1. CS_n never 2'b00, and >=4 cycles all-high between transfers.
- Ch0 req dropped 10 cycles into SHIFT: transfer runs to completion and ack[0] pulses once. No further ch0 transfer follows.
- Reset asserted 50 cycles into a ch1 transfer:
  - CS_n=2'b11, ack=0, busy=0, rx_data=0 immediately.
  - After release, a new ch1 req completes normally.
- NCH=4, WIDTH=8, CLKDIV=2. Reqs 4'b1011 simultaneous from rr=0: service order 0, 1, 3, each CS_n low for 36 cycles.
